// File: rtl/spi_cmd_ctrl_pkg.sv
// Shared types and constants for the SPI command sequencer.
// State encoding, command opcodes and the fixed part of the status byte.
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_LEN,
        ST_WR_DATA,
        ST_RD_DATA,
        ST_IGNORE,
        ST_ABORT
    } state_t;

    localparam logic [7:0] CMD_WRITE   = 8'h02;
    localparam logic [7:0] CMD_READ    = 8'h03;
    localparam logic [7:0] CMD_CLR_ERR = 8'h05;

    localparam logic [6:0] STATUS_BASE = 7'h2A;

endpackage

// File: rtl/spi_cmd_ctrl_if.sv
// Single-byte req/ack register/memory bus between the sequencer and the system.
// The master holds req with stable we/addr/wdata until a one-cycle ack.
interface spi_cmd_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
    logic [7:0]        rdata;
    logic              ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/spi_cmd_ctrl_bus_port.sv
// Bus request port: holds one outstanding transaction and abandons it after TIMEOUT
// unacknowledged cycles. done/timed_out are combinational pulses in the closing cycle.
module spi_bus_port #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              start_we,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [7:0]        start_wdata,
    input  logic              ack,
    output logic              req,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        wdata,
    output logic              done,
    output logic              timed_out
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q;

    assign done      = req & ack;
    // Counter holds the number of unacknowledged cycles already spent, so the
    // request stays up for exactly TIMEOUT cycles.
    assign timed_out = req & ~ack & (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req   <= 1'b0;
            we    <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            cnt_q <= '0;
        end else if (start) begin
            req   <= 1'b1;
            we    <= start_we;
            addr  <= start_addr;
            wdata <= start_wdata;
            cnt_q <= '0;
        end else if (done || timed_out) begin
            req   <= 1'b0;
            cnt_q <= '0;
        end else if (req) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Command sequencer behind the byte-level SPI slave: parses cmd/addr/len/data frames
// into single-byte bus reads and writes and keeps the slave's transmit byte loaded.
module spi_cmd_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           spi_ssel,
    input  logic           spi_data_ready,
    input  logic [7:0]     spi_data_recv,
    output logic [7:0]     spi_data_send,
    spi_cmd_ctrl_if.master bus,
    output logic           busy,
    output logic           err
);
    logic ssel_s1, ssel_s2, ssel_s3;
    logic desel;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        rem_q, rem_d;
    logic [7:0]        hi_q, hi_d;
    logic              we_q, we_d;
    logic [7:0]        rd_q, rd_d;
    logic              err_q, err_d;

    logic              start, pending;
    logic              port_req, port_we, done, timed_out;
    logic [ADDR_W-1:0] port_addr;
    logic [7:0]        port_wdata;
    logic [15:0]       full_addr;
    logic [7:0]        status;

    // Synchroniser resets high so an idle-deselected bus never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ssel_s1 <= 1'b1;
            ssel_s2 <= 1'b1;
            ssel_s3 <= 1'b1;
        end else begin
            ssel_s1 <= spi_ssel;
            ssel_s2 <= ssel_s1;
            ssel_s3 <= ssel_s2;
        end
    end

    assign desel     = ssel_s2 & ~ssel_s3;
    assign full_addr = {hi_q, spi_data_recv};
    assign status    = {err_q, STATUS_BASE};
    assign pending   = port_req & ~done & ~timed_out;

    spi_bus_port #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) u_port (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_we    (we_q),
        .start_addr  (addr_d),
        .start_wdata (spi_data_recv),
        .ack         (bus.ack),
        .req         (port_req),
        .we          (port_we),
        .addr        (port_addr),
        .wdata       (port_wdata),
        .done        (done),
        .timed_out   (timed_out)
    );

    assign bus.req   = port_req;
    assign bus.we    = port_we;
    assign bus.addr  = port_addr;
    assign bus.wdata = port_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            hi_q    <= '0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    // Ack/timeout bookkeeping happens first; the byte (if any) then sees the updated state.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        we_d    = we_q;
        rd_d    = rd_q;
        err_d   = err_q;
        start   = 1'b0;

        if (timed_out) err_d = 1'b1;

        if (done && (state_q == ST_WR_DATA || state_q == ST_RD_DATA)) begin
            addr_d = addr_q + ADDR_W'(1);
            rem_d  = rem_q - 9'd1;
            if (state_q == ST_RD_DATA) rd_d = bus.rdata;
        end

        if (desel) begin
            state_d = pending ? ST_ABORT : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (spi_data_ready) begin
                    state_d = ST_IGNORE;
                    if (spi_data_recv == CMD_WRITE || spi_data_recv == CMD_READ) begin
                        we_d    = (spi_data_recv == CMD_WRITE);
                        state_d = ST_ADDR_HI;
                    end else if (spi_data_recv == CMD_CLR_ERR) begin
                        err_d = 1'b0;
                    end
                end
                ST_ADDR_HI: if (spi_data_ready) begin
                    hi_d    = spi_data_recv;
                    state_d = ST_ADDR_LO;
                end
                ST_ADDR_LO: if (spi_data_ready) begin
                    addr_d  = full_addr[ADDR_W-1:0];
                    state_d = ST_LEN;
                end
                ST_LEN: if (spi_data_ready) begin
                    rem_d = (spi_data_recv == 8'd0) ? 9'd256 : {1'b0, spi_data_recv};
                    if (we_q) begin
                        state_d = ST_WR_DATA;
                    end else begin
                        state_d = ST_RD_DATA;
                        rd_d    = status;
                        start   = 1'b1;
                    end
                end
                ST_WR_DATA: begin
                    if (timed_out || (done && rem_d == 9'd0)) begin
                        state_d = ST_IGNORE;
                    end else if (spi_data_ready) begin
                        if (pending) err_d = 1'b1;
                        else         start = 1'b1;
                    end
                end
                ST_RD_DATA: begin
                    if (timed_out) begin
                        state_d = ST_IGNORE;
                    end else if (spi_data_ready) begin
                        if (pending)             err_d   = 1'b1;
                        else if (rem_d == 9'd0)  state_d = ST_IGNORE;
                        else                     start   = 1'b1;
                    end
                end
                ST_ABORT: if (done || timed_out) state_d = ST_IDLE;
                default: ;
            endcase
        end
    end

    assign spi_data_send = (state_q == ST_RD_DATA) ? rd_q : status;
    assign busy          = (state_q != ST_IDLE);
    assign err           = err_q;

endmodule
